// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one imem request at a time, selects the next PC.
// Optional FETCH_ALIGN_CHECK_EN: an unaligned redirect target raises misalign and halts fetch.
module fetch_unit #(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [3:0]        HALT_OPCODE = 4'b1111
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [1:0]        is_jump,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [3:0]        opcode,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {StIdle, StFetch, StIssue, StHalted} state_e;

    state_e            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       inst_q;
    logic              inst_valid_q;
    logic              halted_q;
    logic              imem_req_q;
`ifdef FETCH_ALIGN_CHECK_EN
    logic              misalign_q;
    logic              bad_target;
`endif

    logic              redirect;
    logic [ADDR_W-1:0] seq_pc;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;

    always_comb begin
        redirect = (is_jump == 2'b10) || ((is_jump == 2'b01) && branch_taken);
        seq_pc   = pc_q + ADDR_W'(4);
`ifdef FETCH_ALIGN_CHECK_EN
        target     = jump_target;
        bad_target = redirect && (jump_target[1:0] != 2'b00);
`else
        // Word alignment is enforced by dropping the low target bits.
        target     = jump_target & ~ADDR_W'(3);
`endif
        next_pc  = redirect ? target : seq_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            halted_q     <= 1'b0;
            imem_req_q   <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    state_q    <= StFetch;
                    imem_req_q <= 1'b1;
                end
                StFetch: begin
                    if (imem_valid) begin
                        inst_q       <= imem_rdata;
                        inst_valid_q <= 1'b1;
                        imem_req_q   <= 1'b0;
                        state_q      <= StIssue;
                    end
                end
                StIssue: begin
                    // Redirect inputs only matter on the cycle the instruction is consumed.
                    if (!stall) begin
                        inst_valid_q <= 1'b0;
                        if (inst_q[31:28] == HALT_OPCODE) begin
                            state_q  <= StHalted;
                            halted_q <= 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                        end else if (bad_target) begin
                            state_q    <= StHalted;
                            halted_q   <= 1'b1;
                            misalign_q <= 1'b1;
`endif
                        end else begin
                            pc_q       <= next_pc;
                            imem_req_q <= 1'b1;
                            state_q    <= StFetch;
                        end
                    end
                end
                StHalted: begin
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign opcode     = inst_q[31:28];
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign halted     = halted_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: random memory latency, stalls, redirects, halts and resets,
// checked each cycle against a transaction-level model of the fetch stream.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [3:0]  HALT_OPCODE = 4'b1111;
    localparam int          NUM_CYCLES  = 4000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic [1:0]  is_jump;
    logic        branch_taken;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [3:0]  opcode;
    logic        inst_valid;
    logic [31:0] pc;
    logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    fetch_unit #(
        .ADDR_W      (32),
        .RESET_PC    (RESET_PC),
        .HALT_OPCODE (HALT_OPCODE)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .is_jump      (is_jump),
        .branch_taken (branch_taken),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .inst         (inst),
        .opcode       (opcode),
        .inst_valid   (inst_valid),
        .pc           (pc),
`ifdef FETCH_ALIGN_CHECK_EN
        .misalign     (misalign),
`endif
        .halted       (halted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cycle    = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s cycle=%0d: got=%h want=%h", tag, cycle, got, want);
        end
    endtask

    // Model of the fetch stream: what the stage should be showing right now.
    logic [31:0] exp_addr;
    logic [31:0] exp_inst;
    logic        exp_req;
    logic        exp_valid;
    logic        exp_halted;
    logic        exp_misalign;
    logic        after_reset;
    logic        req_started;
    int          wait_cnt;
    int          halt_cnt;

    task automatic model_reset();
        exp_addr     = RESET_PC;
        exp_inst     = '0;
        exp_req      = 1'b0;
        exp_valid    = 1'b0;
        exp_halted   = 1'b0;
        exp_misalign = 1'b0;
        after_reset  = 1'b1;
        req_started  = 1'b0;
        wait_cnt     = 0;
        halt_cnt     = 0;
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 3))
            0:       t = $urandom;
            1:       t = 32'hFFFF_FFFC;
            2:       t = 32'($urandom_range(0, 63)) << 2;
            default: t = 32'($urandom_range(0, 255));
        endcase
        return t;
    endfunction

    function automatic logic [31:0] pick_word();
        logic [3:0] op;
        op = ($urandom_range(0, 11) == 0) ? HALT_OPCODE : 4'($urandom_range(0, 14));
        return {op, 28'($urandom)};
    endfunction

    task automatic consume();
        logic redirect;
        redirect = (is_jump == 2'b10) || (is_jump == 2'b01 && branch_taken);
        exp_valid = 1'b0;
        if (exp_inst[31:28] == HALT_OPCODE) begin
            exp_halted = 1'b1;
            halt_cnt   = $urandom_range(3, 12);
            return;
        end
`ifdef FETCH_ALIGN_CHECK_EN
        if (redirect && jump_target[1:0] != 2'b00) begin
            exp_halted   = 1'b1;
            exp_misalign = 1'b1;
            halt_cnt     = $urandom_range(3, 12);
            return;
        end
`endif
        exp_addr = redirect ? (jump_target & ~32'h3) : exp_addr + 32'd4;
        exp_req  = 1'b1;
    endtask

    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        is_jump      = 2'b00;
        branch_taken = 1'b0;
        jump_target  = '0;
        imem_valid   = 1'b0;
        imem_rdata   = '0;
        model_reset();

        for (int c = 0; c < NUM_CYCLES; c++) begin
            @(negedge clk);
            cycle = c;
            check_eq("imem_req", 32'(imem_req), 32'(exp_req));
            check_eq("pc", pc, exp_addr);
            if (exp_req) check_eq("imem_addr", imem_addr, exp_addr);
            check_eq("inst_valid", 32'(inst_valid), 32'(exp_valid));
            if (exp_valid) begin
                check_eq("inst", inst, exp_inst);
                check_eq("opcode", 32'(opcode), 32'(exp_inst[31:28]));
            end
            if (c == 0) check_eq("inst_rst", inst, 32'h0);
            check_eq("halted", 32'(halted), 32'(exp_halted));
`ifdef FETCH_ALIGN_CHECK_EN
            check_eq("misalign", 32'(misalign), 32'(exp_misalign));
`endif

            // Drive this cycle's inputs; the model advances to the state after the next edge.
            rst          = 1'b0;
            stall        = 1'($urandom_range(0, 1));
            is_jump      = 2'($urandom_range(0, 3));
            branch_taken = 1'($urandom_range(0, 1));
            jump_target  = pick_target();
            imem_valid   = 1'($urandom_range(0, 1));
            imem_rdata   = $urandom;

            if (exp_halted && halt_cnt > 0) halt_cnt--;

            if ((exp_halted && halt_cnt == 0) || $urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                model_reset();
            end else if (after_reset) begin
                exp_req     = 1'b1;
                after_reset = 1'b0;
            end else if (exp_req) begin
                if (!req_started) begin
                    wait_cnt    = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
                    req_started = 1'b1;
                end
                if (wait_cnt == 0) begin
                    imem_valid  = 1'b1;
                    imem_rdata  = pick_word();
                    exp_inst    = imem_rdata;
                    exp_valid   = 1'b1;
                    exp_req     = 1'b0;
                    req_started = 1'b0;
                end else begin
                    imem_valid = 1'b0;
                    wait_cnt--;
                end
            end else if (exp_valid) begin
                stall = ($urandom_range(0, 3) == 0);
                if (!stall) consume();
            end
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_errors);
        $finish;
    end

endmodule
